reg_both_pip: RTL and testbench

- Parameterised pipeline of DEPTH fully registered valid/ready handshake slices. Used to break long timing paths between a producer and a consumer.
- Each slice registers the forward path (valid, data) and the backward path (ready) using a one-entry skid buffer. No combinational path runs from any input to any output.
- Sits between an upstream source and a downstream sink. Both sides follow the standard valid/ready protocol: a transfer occurs on a clk rising edge where valid and ready are both 1.

---
 rtl/reg_both_pip.sv | 132 +++++++++++++
 tb/tb_reg_both_pip.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_both_pip.sv
// reg_both_pip: cascade of DEPTH fully registered valid/ready slices.
//
// Each slice has a main register (mv/md) and a one-entry skid register
// (sv/sd). Every output is a flop output, so this block has no combinational
// path from any input to any output. That breaks long timing paths in both
// directions between a producer and a consumer.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous reset, active-low
//   master_valid_in   upstream valid
//   master_data_in    upstream data (WIDTH bits)
//   slave_ready_out   ready to upstream (registered, ~skid valid of slice 0)
//   master_valid_out  downstream valid (registered)
//   master_data_out   downstream data (registered)
//   slave_ready_in    downstream ready
//   occupancy         words held in the pipe; present only when the macro
//                     REG_BOTH_PIP_OCC_EN is defined
//
// Parameters:
//   DEPTH  number of slices, >= 1 (capacity is 2*DEPTH words)
//   WIDTH  data width in bits

module reg_both_pip #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             master_valid_in,
    input  logic [WIDTH-1:0] master_data_in,
    output logic             slave_ready_out,
    output logic             master_valid_out,
    output logic [WIDTH-1:0] master_data_out,
    input  logic             slave_ready_in
`ifdef REG_BOTH_PIP_OCC_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_both_pip: DEPTH must be >= 1");
    end

    // Index k of the forward chain is the input of slice k. Index k+1 is
    // the output of slice k. In the backward chain, bwd_ready[k] is the ready
    // into slice k, and bwd_ready[DEPTH] is the downstream ready.
    logic [DEPTH:0]   fwd_valid;
    logic [WIDTH-1:0] fwd_data [DEPTH+1];
    logic [DEPTH:0]   bwd_ready;

    assign fwd_valid[0]     = master_valid_in;
    assign fwd_data[0]      = master_data_in;
    assign bwd_ready[DEPTH] = slave_ready_in;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        logic             mv_q;
        logic             sv_q;
        logic [WIDTH-1:0] md_q;
        logic [WIDTH-1:0] sd_q;
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             out_ready;
        logic             acc;

        assign in_valid  = fwd_valid[i];
        assign in_data   = fwd_data[i];
        assign out_ready = bwd_ready[i+1];
        // Input ready is ~sv_q, so this is the upstream transfer condition.
        assign acc       = in_valid & ~sv_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mv_q <= 1'b0;
                sv_q <= 1'b0;
                md_q <= '0;
                sd_q <= '0;
            end else if (!mv_q || out_ready) begin
                // Main register is free or draining. The skid holds the
                // older word, so it has priority over the input.
                if (sv_q) begin
                    mv_q <= 1'b1;
                    md_q <= sd_q;
                    sv_q <= 1'b0;
                end else begin
                    mv_q <= in_valid;
                    if (acc) begin
                        md_q <= in_data;
                    end
                end
            end else if (acc) begin
                // Main is stalled. Park the word that arrived under the
                // registered ready.
                sv_q <= 1'b1;
                sd_q <= in_data;
            end
        end

        assign fwd_valid[i+1] = mv_q;
        assign fwd_data[i+1]  = md_q;
        assign bwd_ready[i]   = ~sv_q;
    end

    assign slave_ready_out  = bwd_ready[0];
    assign master_valid_out = fwd_valid[DEPTH];
    assign master_data_out  = fwd_data[DEPTH];

`ifdef REG_BOTH_PIP_OCC_EN
    localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

    logic             up_fire;
    logic             down_fire;
    logic [OCC_W-1:0] occ_q;

    assign up_fire   = master_valid_in & slave_ready_out;
    assign down_fire = master_valid_out & slave_ready_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (up_fire && !down_fire) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!up_fire && down_fire) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reg_both_pip.sv
// Directed self-checking bench for reg_both_pip (DEPTH=4, WIDTH=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_reg_both_pip;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mvi = 1'b0;
    logic [15:0] mdi = '0;
    logic        sri = 1'b0;
    logic        sro;
    logic        mvo;
    logic [15:0] mdo;
`ifdef REG_BOTH_PIP_OCC_EN
    logic [3:0]  occ;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    reg_both_pip #(
        .DEPTH(4),
        .WIDTH(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .master_valid_in  (mvi),
        .master_data_in   (mdi),
        .slave_ready_out  (sro),
        .master_valid_out (mvo),
        .master_data_out  (mdo),
        .slave_ready_in   (sri)
`ifdef REG_BOTH_PIP_OCC_EN
        ,
        .occupancy        (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        mvi = 1'b0;
        mdi = '0;
        sri = 1'b0;
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (mvo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", mvo);
        end
        n_checks++;
        if (mdo !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0000", mdo);
        end
        n_checks++;
        if (sro !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", sro);
        end
        repeat (2) step();
        rst = 1'b1;
    endtask

    // Back-to-back stream 16..79 with an always-ready sink.
    task automatic test_stream;
        logic        exp_v;
        logic [15:0] exp_d;
        do_reset();
        sri = 1'b1;
        for (int s = 1; s <= 70; s++) begin
            mvi = (s <= 64);
            mdi = 16'(16 + s - 1);
            step();
            exp_v = (s >= 4) && (s <= 67);
            exp_d = 16'(16 + s - 4);
            n_checks++;
            if (mvo !== exp_v) begin
                n_fail++;
                $display("FAIL stream_valid step %0d: got %b expected %b", s, mvo, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (mdo !== exp_d) begin
                    n_fail++;
                    $display("FAIL stream_data step %0d: got %0d expected %0d", s, mdo, exp_d);
                end
            end
            n_checks++;
            if (sro !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready step %0d: got %b expected 1", s, sro);
            end
        end
        mvi = 1'b0;
    endtask

    // Full downstream stall: 8 words fill the pipe, then it drains in order.
    task automatic test_stall;
        int word;
        do_reset();
        sri  = 1'b0;
        mvi  = 1'b1;
        word = 100;
        for (int s = 1; s <= 12; s++) begin
            mdi = 16'(word);
            if (sro) word++;
            step();
            n_checks++;
            if (sro !== (s < 8)) begin
                n_fail++;
                $display("FAIL stall_ready step %0d: got %b expected %b", s, sro, (s < 8));
            end
            if (s >= 4) begin
                n_checks++;
                if (mvo !== 1'b1 || mdo !== 16'd100) begin
                    n_fail++;
                    $display("FAIL stall_hold step %0d: got v=%b d=%0d expected v=1 d=100",
                             s, mvo, mdo);
                end
            end
        end
        n_checks++;
        if (word - 100 !== 8) begin
            n_fail++;
            $display("FAIL stall_accepted: got %0d expected 8", word - 100);
        end
        sri = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            mdi = 16'(word);
            if (sro) word++;
            step();
            n_checks++;
            if (mvo !== 1'b1 || mdo !== 16'(100 + k)) begin
                n_fail++;
                $display("FAIL drain_data step %0d: got v=%b d=%0d expected v=1 d=%0d",
                         k, mvo, mdo, 100 + k);
            end
            n_checks++;
            if (sro !== (k >= 4)) begin
                n_fail++;
                $display("FAIL drain_ready step %0d: got %b expected %b", k, sro, (k >= 4));
            end
        end
        mvi = 1'b0;
    endtask

    // Sink ready toggles every cycle during a 32-word stream.
    task automatic test_toggle;
        int          sent;
        int          rcvd;
        logic        stalled;
        logic [15:0] held;
        do_reset();
        sent    = 0;
        rcvd    = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 200 && rcvd < 32; cyc++) begin
            sri = (cyc % 2 == 0);
            mvi = (sent < 32);
            mdi = 16'(sent);
            if (stalled) begin
                n_checks++;
                if (mvo !== 1'b1 || mdo !== held) begin
                    n_fail++;
                    $display("FAIL toggle_stable cyc %0d: got v=%b d=%0d expected v=1 d=%0d",
                             cyc, mvo, mdo, held);
                end
            end
            if (mvo && sri) begin
                n_checks++;
                if (mdo !== 16'(rcvd)) begin
                    n_fail++;
                    $display("FAIL toggle_order: got %0d expected %0d", mdo, rcvd);
                end
                rcvd++;
            end
            stalled = mvo && !sri;
            held    = mdo;
            if (mvi && sro) sent++;
            step();
        end
        n_checks++;
        if (rcvd !== 32) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d expected 32", rcvd);
        end
        mvi = 1'b0;
        sri = 1'b1;
        repeat (6) step();
        n_checks++;
        if (mvo !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_extra: got valid %b expected 0", mvo);
        end
    endtask

    // One beat into a stalled sink.
    task automatic test_single;
        do_reset();
        sri = 1'b0;
        mvi = 1'b1;
        mdi = 16'h00AB;
        for (int s = 1; s <= 6; s++) begin
            step();
            mvi = 1'b0;
            mdi = '0;
            if (s < 4) begin
                n_checks++;
                if (mvo !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_early step %0d: got %b expected 0", s, mvo);
                end
            end else begin
                n_checks++;
                if (mvo !== 1'b1 || mdo !== 16'h00AB) begin
                    n_fail++;
                    $display("FAIL single_hold step %0d: got v=%b d=%h expected v=1 d=00ab",
                             s, mvo, mdo);
                end
            end
        end
        sri = 1'b1;
        step();
        n_checks++;
        if (mvo !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gone: got %b expected 0", mvo);
        end
    endtask

    // Asynchronous reset with the pipe half full, then a fresh stream.
    task automatic test_reset_mid;
        do_reset();
        sri = 1'b0;
        mvi = 1'b1;
        for (int s = 0; s < 4; s++) begin
            mdi = 16'(100 + s);
            step();
        end
        mvi = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (mvo !== 1'b0 || mdo !== 16'h0 || sro !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b d=%h r=%b expected v=0 d=0000 r=1",
                     mvo, mdo, sro);
        end
        repeat (2) step();
        rst = 1'b1;
        sri = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            mvi = (s <= 8);
            mdi = 16'(200 + s - 1);
            step();
            if (s < 4 || s > 11) begin
                n_checks++;
                if (mvo !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_stale step %0d: got v=%b d=%0d expected v=0",
                             s, mvo, mdo);
                end
            end else begin
                n_checks++;
                if (mvo !== 1'b1 || mdo !== 16'(200 + s - 4)) begin
                    n_fail++;
                    $display("FAIL midreset_data step %0d: got v=%b d=%0d expected v=1 d=%0d",
                             s, mvo, mdo, 200 + s - 4);
                end
            end
        end
        mvi = 1'b0;
    endtask

`ifdef REG_BOTH_PIP_OCC_EN
    task automatic test_occupancy;
        int          word;
        logic [3:0]  exp;
        do_reset();
        n_checks++;
        if (occ !== 4'd0) begin
            n_fail++;
            $display("FAIL occ_reset: got %0d expected 0", occ);
        end
        sri  = 1'b0;
        mvi  = 1'b1;
        word = 100;
        for (int s = 1; s <= 10; s++) begin
            mdi = 16'(word);
            if (sro) word++;
            step();
            exp = (s < 8) ? 4'(s) : 4'd8;
            n_checks++;
            if (occ !== exp) begin
                n_fail++;
                $display("FAIL occ_fill step %0d: got %0d expected %0d", s, occ, exp);
            end
        end
        // Drain: no accepts while the slice-0 skid empties, then steady flow.
        sri = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            mdi = 16'(word);
            if (sro) word++;
            step();
            exp = (k < 4) ? 4'(8 - k) : 4'd4;
            n_checks++;
            if (occ !== exp) begin
                n_fail++;
                $display("FAIL occ_flow step %0d: got %0d expected %0d", k, occ, exp);
            end
        end
        mvi = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_single();
        test_reset_mid();
`ifdef REG_BOTH_PIP_OCC_EN
        test_occupancy();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
